// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scan path.
// Key index is {col[1:0], row[1:0]}, so ascending index equals scan order.
package kp_pkg;

  localparam int KP_COLS = 4;
  localparam int KP_ROWS = 4;
  localparam logic [3:0] KEY_CLEAR = 4'h0;
  localparam logic [3:0] KEY_SHIFT = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_e;

  // Lowest-numbered active-low row wins.
  function automatic logic [1:0] first_low(input logic [3:0] rows_n);
    first_low = 2'd0;
    for (int r = KP_ROWS - 1; r >= 0; r--) begin
      if (!rows_n[r]) first_low = 2'(r);
    end
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones
// so idle pulled-up lines never look like a press coming out of reset.
module kp_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/kp_scan_ctrl.sv
// Column-scanning keypad controller: one frame result per 4 dwells, debounced
// over whole frames; accepted presses pulse valid for one cycle with d held.
module kp_scan_ctrl
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] d,
  output logic       valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);

  logic [3:0]    row_s;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic          acc_hit_q, acc_hit_d;
  logic [3:0]    acc_key_q, acc_key_d;
  kp_state_e     state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;

  logic          sample, frame_end, col_hit, frame_hit;
  logic [3:0]    col_key, frame_key;

  kp_sync2 #(.W(KP_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (row_n),
    .q_o   (row_s)
  );

  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_q == 2'd3);
    col_hit   = (row_s != 4'hF);
    col_key   = {col_q, first_low(row_s)};
    // Column 3's sample is folded in combinationally so the frame result is complete at frame end.
    frame_hit = acc_hit_q | col_hit;
    frame_key = acc_hit_q ? acc_key_q : col_key;

    div_d = sample ? '0 : div_q + 1'b1;
    col_d = sample ? col_q + 2'd1 : col_q;

    acc_hit_d = acc_hit_q;
    acc_key_d = acc_key_q;
    if (frame_end) begin
      acc_hit_d = 1'b0;
      acc_key_d = 4'h0;
    end else if (sample && col_hit && !acc_hit_q) begin
      acc_hit_d = 1'b1;
      acc_key_d = col_key;
    end

    cnt_inc = cnt_q + 1'b1;
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    down_d  = down_q;

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_hit) begin
            state_d = ST_CAND;
            cand_d  = frame_key;
            cnt_d   = CW'(1);
          end
        end
        ST_CAND: begin
          if (!frame_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (frame_key == cand_q) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
              key_d   = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = frame_key;
            cnt_d  = CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!frame_hit) begin
            state_d = ST_RELEASE;
            cnt_d   = CW'(1);
          end
        end
        ST_RELEASE: begin
          if (frame_hit) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            down_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      col_q     <= 2'd0;
      acc_hit_q <= 1'b0;
      acc_key_q <= 4'h0;
      state_q   <= ST_IDLE;
      cand_q    <= 4'h0;
      cnt_q     <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      acc_hit_q <= acc_hit_d;
      acc_key_q <= acc_key_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
    end
  end

  assign col_n    = ~(4'b0001 << col_q);
  assign d        = key_q;
  assign valid    = valid_q;
  assign key_down = down_q;

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Bench for kp_scan_ctrl: simulated keypad matrix, run-length debounce model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_kp_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] d;
  logic       valid;
  logic       key_down;

  logic [15:0] keys = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int k        = 0;
  bit rst_edge = 1'b1;
  bit live     = 1'b0;

  // Reference model state
  bit          held;
  bit          last_hit;
  logic [3:0]  last_key;
  int          run;
  logic [15:0] fmask;
  logic        exp_valid;
  logic        exp_kd;
  logic [3:0]  exp_d;
  logic [3:0]  exp_col;
  bit          mhit;
  logic [3:0]  mkey;

  kp_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .d        (d),
    .valid    (valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column line.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[c*4 + r]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    live <= 1'b1;
    if (reset) begin
      k        <= 0;
      rst_edge <= 1'b1;
    end else begin
      k        <= k + 1;
      rst_edge <= 1'b0;
    end
  end

  // Model update and per-cycle compare
  always @(negedge clk) begin
    if (live) begin
      if (rst_edge) begin
        held = 1'b0; last_hit = 1'b0; last_key = 4'h0; run = 0; fmask = 16'h0;
        exp_valid = 1'b0; exp_d = 4'h0; exp_kd = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (k % FRAME == FRAME / 2) fmask = keys;
        if (k > 0 && k % FRAME == 0) begin
          mhit = (fmask != 16'h0);
          mkey = 4'h0;
          for (int i = 15; i >= 0; i--) if (fmask[i]) mkey = 4'(i);
          if (mhit == last_hit && (!mhit || mkey == last_key)) run++;
          else run = 1;
          last_hit = mhit;
          last_key = mkey;
          if (!held && mhit && run == DEB) begin
            held = 1'b1; exp_valid = 1'b1; exp_d = mkey;
          end else if (held && !mhit && run == DEB) begin
            held = 1'b0;
          end
          exp_kd = held;
        end
      end
      exp_col = 4'b0001 << ((k / SCAN_DIV) % 4);
      exp_col = ~exp_col;
      check("col_n", col_n, exp_col);
      check("valid", valid, exp_valid);
      check("d", d, exp_d);
      check("key_down", key_down, exp_kd);
      if (valid === 1'b1) pulses++;
    end
  end

  task automatic wait_frame_end();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(k > 0 && k % FRAME == 0) && n < 4 * FRAME);
    if (!(k > 0 && k % FRAME == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_wait: timed out after %0d cycles, required a frame end", n);
    end
  endtask

  task automatic frames(input int n, input logic [15:0] mask);
    keys = mask;
    repeat (n) wait_frame_end();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    logic [3:0] rot [4];
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

    // 1: reset values and column rotation
    do_reset();
    check("rst_col_n", col_n, 4'b1110);
    check("rst_d", d, 4'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check("col_rotate", col_n, rot[i]);
    end

    // 2: hold col2/row1 for 10 frames
    p0 = pulses;
    frames(3, 16'h0200);
    check("t2_valid", valid, 1'b1);
    check("t2_d", d, 4'h9);
    check("t2_key_down", key_down, 1'b1);
    frames(7, 16'h0200);
    check("t2_pulses", pulses - p0, 1);
    frames(2, 16'h0000);
    check("t2_down_held", key_down, 1'b1);
    frames(1, 16'h0000);
    check("t2_released", key_down, 1'b0);

    // 3: bouncing col1/row0
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      frames(1, (i % 2 == 0) ? 16'h0010 : 16'h0000);
      check("t3_key_down", key_down, 1'b0);
    end
    check("t3_pulses", pulses - p0, 0);

    // 4: shift key with one empty frame mid-hold
    p0 = pulses;
    frames(3, 16'h0080);
    check("t4_valid", valid, 1'b1);
    check("t4_d", d, 4'h7);
    frames(2, 16'h0080);
    frames(1, 16'h0000);
    check("t4_glitch_down", key_down, 1'b1);
    frames(3, 16'h0080);
    check("t4_rehold_down", key_down, 1'b1);
    frames(3, 16'h0000);
    check("t4_released", key_down, 1'b0);
    check("t4_pulses", pulses - p0, 1);

    // 5: two keys, scan order picks col0/row3
    p0 = pulses;
    frames(3, 16'h0018);
    check("t5_valid", valid, 1'b1);
    check("t5_d", d, 4'h3);
    frames(4, 16'h0010);
    check("t5_still_down", key_down, 1'b1);
    check("t5_d_hold", d, 4'h3);
    frames(3, 16'h0000);
    check("t5_released", key_down, 1'b0);
    check("t5_pulses", pulses - p0, 1);

    // 6: reset during candidate debounce
    p0 = pulses;
    frames(2, 16'h0200);
    @(negedge clk);
    reset = 1'b1;
    keys  = 16'h0000;
    @(negedge clk);
    check("t6_rst_col_n", col_n, 4'b1110);
    check("t6_rst_d", d, 4'h0);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_key_down", key_down, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frames(3, 16'h0020);
    check("t6_valid", valid, 1'b1);
    check("t6_d", d, 4'h5);
    frames(3, 16'h0000);
    check("t6_released", key_down, 1'b0);
    check("t6_pulses", pulses - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
